result_to_bcd_digits: RTL and testbench
=======================================

RESULT_TO_BCD_DIGITS -- requirements
Module: result_to_bcd_digits

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of the signed two's-complement input value.
REQ-002 SHALL have parameter DIGITS, default 5: number of BCD digit outputs; DIGITS SHALL be large enough to hold 2^(WIDTH-1) in decimal.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: request to convert value; sampled only in IDLE.
REQ-006 SHALL have port value  input  WIDTH: signed two's-complement result to display.
REQ-007 SHALL have port busy  output  1: high while a conversion is in progress.
REQ-008 SHALL have port done  output  1: one-cycle pulse marking updated outputs.
REQ-009 SHALL have port digits  output  4*DIGITS: nibble k = decimal digit of weight 10^k, or 4'hF for a blanked digit; each nibble feeds one 7-segment converter directly.
REQ-010 SHALL have port negative  output  1: sign of the last converted value.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, BLANK; reset state IDLE.
REQ-012 IDLE: start=1 at an edge SHALL capture |value| into a WIDTH-bit unsigned shift register, capture sign into an internal register, clear the BCD accumulator, and move to SHIFT; busy=1 from the next cycle.
REQ-013 |value| SHALL be computed as the unsigned two's-complement negation when value[WIDTH-1]=1; most-negative input (-32768 at WIDTH=16) SHALL yield magnitude 32768.
REQ-014 SHIFT SHALL perform exactly WIDTH double-dabble iterations, one per cycle: first add 3 to every BCD nibble >= 5, then shift {BCD, binary} left by one bit.
REQ-015 After the WIDTH-th iteration, SHALL move to BLANK.
REQ-016 BLANK (one cycle) SHALL load digits: nibble 0 always the true digit; nibble k>0 SHALL be 4'hF when it and all higher nibbles are zero, else the true digit (interior zeros kept).
REQ-017 At the BLANK edge, negative SHALL load the captured sign, done SHALL be 1 for exactly the following cycle, busy SHALL go 0, state SHALL return to IDLE.
REQ-018 Latency: start sampled at edge N -> done high and outputs valid in the cycle after edge N+WIDTH+1 (17 cycles for WIDTH=16).
REQ-019 start while busy=1 SHALL be ignored; no queuing.
REQ-020 start high in the done cycle SHALL be accepted (state already IDLE).
REQ-021 digits and negative SHALL hold their values between completions; value changes during a conversion SHALL NOT affect the result.
REQ-022 Zero SHALL never set negative.

Reset
REQ-023 rst=1 at an edge SHALL, in any state including mid-SHIFT, force: state IDLE, busy=0, done=0, negative=0, nibble 0 = 4'd0, all other nibbles = 4'hF; the in-flight conversion SHALL be discarded.
REQ-024 rst SHALL take priority over start in the same cycle.

Verification
REQ-025 value=0, start pulse -> done 17 cycles later; digits (k4..k0)=F,F,F,F,0; negative=0.
REQ-026 value=12345 -> digits 1,2,3,4,5; negative=0; busy high for exactly 17 cycles.
REQ-027 value=-32768 -> digits 3,2,7,6,8, negative=1; value=-1 -> F,F,F,F,1, negative=1.
REQ-028 value=100 -> F,F,1,0,0 (interior zeros kept); value=32767 -> 3,2,7,6,7.
REQ-029 start=1 with value=5, then start=1 with value=9 at cycle 5 -> single done with digit0=5; a second start held into the done cycle -> second conversion yields 9.
REQ-030 rst asserted at cycle 8 of a conversion of 999 -> no done pulse, outputs return to reset values; a subsequent conversion of 7 completes normally in 17 cycles.

Source files
------------

// File: rtl/result_to_bcd_digits.sv
// Signed binary to blanked BCD digit converter using sequential double-dabble.
// One iteration per clock, WIDTH iterations, then a single cycle to apply
// leading-zero blanking and publish the digits with a one-cycle done pulse.
module result_to_bcd_digits #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  negative
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned DD_W  = BCD_W + WIDTH;

    // Reset display: units digit shows 0, every higher digit blanked.
    localparam logic [BCD_W-1:0] RESET_DIGITS = {BCD_W{1'b1}} << 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   bin;
    logic [BCD_W-1:0]   bcd;
    logic [CNT_W-1:0]   iter;
    logic               sign;

    logic [WIDTH-1:0]   magnitude;
    logic [BCD_W-1:0]   bcd_adj;
    logic [DD_W-1:0]    dd_next;
    logic [BCD_W-1:0]   blanked;
    logic               leading;

    // Magnitude of the input; the most-negative value maps to 2^(WIDTH-1).
    always_comb begin
        magnitude = value;
        if (value[WIDTH-1]) begin
            magnitude = ~value + WIDTH'(1);
        end
    end

    // Double-dabble step: add 3 to each nibble >= 5, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
        dd_next = {bcd_adj, bin} << 1;
    end

    // Leading-zero blanking; the units digit is never blanked.
    always_comb begin
        blanked = bcd;
        leading = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            if (leading && (bcd[4*k +: 4] == 4'd0)) begin
                blanked[4*k +: 4] = 4'hF;
            end else begin
                leading = 1'b0;
            end
        end
    end

    // Conversion FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bin      <= '0;
            bcd      <= '0;
            iter     <= '0;
            sign     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            negative <= 1'b0;
            digits   <= RESET_DIGITS;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin   <= magnitude;
                        sign  <= value[WIDTH-1];
                        bcd   <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd  <= dd_next[DD_W-1:WIDTH];
                    bin  <= dd_next[WIDTH-1:0];
                    iter <= iter + CNT_W'(1);
                    if (iter == CNT_W'(WIDTH - 1)) begin
                        state <= BLANK;
                    end
                end
                BLANK: begin
                    digits   <= blanked;
                    negative <= sign;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_to_bcd_digits.sv
// Bench for result_to_bcd_digits: directed corner values plus random values,
// checked against an arithmetic decimal-digit model.
module tb_result_to_bcd_digits;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DIGITS = 5;
    localparam int unsigned LAT    = WIDTH + 1;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [WIDTH-1:0]     value;
    logic                 busy;
    logic                 done;
    logic [4*DIGITS-1:0]  digits;
    logic                 negative;

    int errors = 0;
    int checks = 0;

    result_to_bcd_digits #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .digits   (digits),
        .negative (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decimal digits of |v|, higher-order zeros shown as F.
    function automatic logic [4*DIGITS-1:0] model_digits(input int v);
        logic [4*DIGITS-1:0] r;
        longint mag;
        longint p;
        mag = (v < 0) ? -longint'(v) : longint'(v);
        p = 1;
        r = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (k > 0 && mag < p) r[4*k +: 4] = 4'hF;
            else                  r[4*k +: 4] = 4'((mag / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Present a start pulse; returns #1 after the sampling edge.
    task automatic kick(input int v);
        start = 1'b1;
        value = WIDTH'(v);
        @(posedge clk); #1;
    endtask

    // Wait for done (bounded), optionally re-asserting start at cycle icyc.
    task automatic wait_done(input int v, input string tag, input int icyc, input int ival);
        int edges;
        int busy_cnt;
        edges = 0;
        busy_cnt = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            if (edges == icyc) begin
                start = 1'b1;
                value = WIDTH'(ival);
            end else begin
                start = 1'b0;
                value = WIDTH'($urandom);
            end
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        check({tag, " latency"},  64'(edges), 64'(LAT));
        check({tag, " busy_len"}, 64'(busy_cnt), 64'(LAT));
        check({tag, " digits"},   64'(digits), 64'(model_digits(v)));
        check({tag, " negative"}, 64'(negative), 64'(v < 0));
        check({tag, " busy_off"}, 64'(busy), 64'(0));
    endtask

    task automatic convert(input int v, input string tag);
        logic [4*DIGITS-1:0] held;
        kick(v);
        wait_done(v, tag, -1, 0);
        held = digits;
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 64'(done), 64'(0));
        check({tag, " hold"},       64'(digits), 64'(held));
    endtask

    initial begin
        int dcount;
        int rv;
        rst   = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",     64'(busy), 64'(0));
        check("reset done",     64'(done), 64'(0));
        check("reset negative", 64'(negative), 64'(0));
        check("reset digits",   64'(digits), 64'h000FFFF0);
        rst = 1'b0;
        @(posedge clk); #1;

        convert(0, "zero");
        convert(12345, "12345");
        convert(-32768, "min");
        convert(-1, "minus1");
        convert(100, "100");
        convert(32767, "max");
        convert(9, "9");
        convert(-10000, "m10000");

        for (int i = 0; i < 20; i++) begin
            rv = int'($signed(16'($urandom)));
            convert(rv, $sformatf("rand%0d", i));
        end

        // Start during busy is ignored; start held in the done cycle is taken.
        kick(5);
        wait_done(5, "ignore_busy", 4, 9);
        start = 1'b1;
        value = WIDTH'(9);
        @(posedge clk); #1;
        wait_done(9, "start_in_done", -1, 0);
        @(posedge clk); #1;

        // Leave a negative result so reset of negative is observable.
        convert(-42, "m42");

        // Reset mid-conversion, with start also high: reset wins.
        kick(999);
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst   = 1'b1;
        start = 1'b1;
        value = WIDTH'(77);
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        check("midrst busy",     64'(busy), 64'(0));
        check("midrst done",     64'(done), 64'(0));
        check("midrst negative", 64'(negative), 64'(0));
        check("midrst digits",   64'(digits), 64'h000FFFF0);
        dcount = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("midrst no_done",  64'(dcount), 64'(0));
        check("midrst idle",     64'(busy), 64'(0));
        convert(7, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
